cube_spi_frame_rx: RTL and testbench

Upstream stage of the cube display core. It receives the 432-bit cube orientation (54 squares × 8-bit colour code) from the microcontroller over SPI, in the clk domain. It checks frame length and colour codes, then commits the frame to a double-buffered output register. The output is handed to the display core with a valid/ack handshake, and a done flag goes back to the microcontroller once the core has taken the frame.

---
 rtl/cube_spi_frame_rx.sv | 145 ++++++++++++++
 tb/tb_cube_spi_frame_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_spi_frame_rx.sv
// rtl/cube_spi_frame_rx.sv - SPI receiver for the 54-square cube orientation frame
// Synchronises the MC SPI pins, validates the frame and commits it to a double-buffered output.
module cube_spi_frame_rx #(
   parameter int NUM_BYTES   = 54,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_CODE    = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   sdi,
   input  logic                   load,
   output logic [NUM_BYTES*8-1:0] orientation,
   output logic                   frame_valid,
   input  logic                   frame_ack,
   output logic                   frame_error,
   output logic                   done,
   output logic [5:0]             byte_count
);

   localparam int W = NUM_BYTES * 8;

   typedef enum logic [1:0] {IDLE, RECEIVE, CHECK, HOLD} state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
   logic                   sck_d, load_d;
   logic                   sck_s, sdi_s, load_s;
   logic                   sck_rise, load_rise, load_fall;

   logic [W-1:0] shreg;
   logic [2:0]   bit_cnt;
   logic         code_err, ovf;
   logic         frame_ok, start, shift, accept, reject;

   // load chain resets high so a transfer already running at reset release shows no rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sync  <= '0;
         sdi_sync  <= '0;
         load_sync <= '1;
         sck_d     <= 1'b0;
         load_d    <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
         load_sync <= {load_sync[SYNC_STAGES-2:0], load};
         sck_d     <= sck_s;
         load_d    <= load_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign load_s    = load_sync[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_d;
   assign load_rise = load_s & ~load_d;
   assign load_fall = ~load_s & load_d;

   assign frame_ok = (bit_cnt == 3'd0) && (byte_count == 6'(NUM_BYTES)) && !code_err && !ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      shift      = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            if (load_rise) begin
               start      = 1'b1;
               next_state = RECEIVE;
            end
         end
         RECEIVE: begin
            shift = sck_rise & load_s;
            if (load_fall) next_state = CHECK;
         end
         CHECK: begin
            if (frame_ok) begin
               accept     = 1'b1;
               next_state = HOLD;
            end else begin
               reject     = 1'b1;
               next_state = frame_valid ? HOLD : IDLE;
            end
         end
         HOLD: begin
            if (load_rise) begin
               start      = 1'b1;
               next_state = RECEIVE;
            end else if (frame_ack && frame_valid) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg       <= '0;
         bit_cnt     <= 3'd0;
         byte_count  <= 6'd0;
         code_err    <= 1'b0;
         ovf         <= 1'b0;
         orientation <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         done        <= 1'b0;
      end else begin
         frame_error <= reject;
         if (start) begin
            bit_cnt    <= 3'd0;
            byte_count <= 6'd0;
            code_err   <= 1'b0;
            ovf        <= 1'b0;
         end else if (shift) begin
            shreg   <= {shreg[W-2:0], sdi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (byte_count != 6'd63) byte_count <= byte_count + 6'd1;
               if (byte_count >= 6'(NUM_BYTES)) ovf <= 1'b1;
               if ({shreg[6:0], sdi_s} > 8'(MAX_CODE)) code_err <= 1'b1;
            end
         end
         // a commit in the same cycle as an ack keeps the new frame valid
         if (accept) begin
            orientation <= shreg;
            frame_valid <= 1'b1;
            done        <= 1'b0;
         end else if (frame_ack && frame_valid) begin
            frame_valid <= 1'b0;
            done        <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cube_spi_frame_rx.sv
// tb/tb_cube_spi_frame_rx.sv - self-checking bench for cube_spi_frame_rx
// Scoreboard of expected commit/reject events checked by a negedge monitor.
`timescale 1ns/1ps
module tb_cube_spi_frame_rx;

   localparam int NB = 54;
   localparam int W  = NB * 8;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sck = 1'b0;
   logic         sdi = 1'b0;
   logic         load = 1'b0;
   logic         frame_ack = 1'b0;
   logic [W-1:0] orientation;
   logic         frame_valid, frame_error, done;
   logic [5:0]   byte_count;

   typedef struct {
      logic         commit;
      logic [W-1:0] data;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         e;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [7:0]   fb [0:63];
   logic [W-1:0] frame_a;
   logic [W-1:0] prev_o;
   logic         prev_v = 1'b0;
   logic         prev_err = 1'b0;
   logic         ev_c;

   cube_spi_frame_rx #(.NUM_BYTES(NB), .SYNC_STAGES(SYNC), .MAX_CODE(5)) dut (
      .clk(clk), .reset(rst), .sck(sck), .sdi(sdi), .load(load),
      .orientation(orientation), .frame_valid(frame_valid), .frame_ack(frame_ack),
      .frame_error(frame_error), .done(done), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_o   = orientation;
         prev_v   = frame_valid;
         prev_err = frame_error;
      end else begin
         if (prev_err) chk("err_one_cycle", W'(frame_error), '0);
         ev_c = (frame_valid && !prev_v) || (orientation != prev_o);
         if (ev_c || frame_error) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_event", W'({ev_c, frame_error}), '0);
            end else begin
               e = sb_q.pop_front();
               chk("event_commit", W'(ev_c), W'(e.commit));
               chk("event_error", W'(frame_error), W'(!e.commit));
               if (e.commit) chk("orientation", orientation, e.data);
            end
         end
         prev_o   = orientation;
         prev_v   = frame_valid;
         prev_err = frame_error;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic send_bit(input logic b);
      sdi = b;
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic frame_begin();
      tick(4);
      load = 1'b1;
      tick(4);
   endtask

   task automatic frame_end();
      tick(4);
      load = 1'b0;
   endtask

   function automatic logic [W-1:0] pack_frame();
      logic [W-1:0] v;
      for (int i = 0; i < NB; i++) v[W-1-8*i -: 8] = fb[i];
      return v;
   endfunction

   task automatic push_exp(input logic commit, input logic [W-1:0] data);
      exp_t x;
      x.commit = commit;
      x.data   = data;
      sb_q.push_back(x);
   endtask

   task automatic send_frame(input int nbytes, input int extra_bits);
      frame_begin();
      for (int i = 0; i < nbytes; i++) send_byte(fb[i]);
      for (int i = 0; i < extra_bits; i++) send_bit(1'b0);
      frame_end();
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && sb_q.size() != 0; i++) tick(1);
      tick(4);
      chk("sb_drain", W'(sb_q.size()), '0);
   endtask

   task automatic ack_pulse();
      frame_ack = 1'b1;
      tick(1);
      frame_ack = 1'b0;
      tick(1);
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 64; i++) fb[i] = v;
   endtask

   initial begin
      do_reset();
      chk("rst_orientation", orientation, '0);
      chk("rst_valid", W'(frame_valid), '0);
      chk("rst_error", W'(frame_error), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_byte_count", W'(byte_count), '0);

      // 1: legal frame 0..5 repeating, then ack
      for (int i = 0; i < 64; i++) fb[i] = 8'(i % 6);
      push_exp(1'b1, pack_frame());
      send_frame(NB, 0);
      drain();
      chk("t1_valid", W'(frame_valid), W'(1));
      chk("t1_first_byte", W'(orientation[W-1 -: 8]), W'(8'h00));
      chk("t1_last_byte", W'(orientation[7:0]), W'(8'h05));
      chk("t1_error", W'(frame_error), '0);
      ack_pulse();
      chk("t1_ack_valid", W'(frame_valid), '0);
      chk("t1_ack_done", W'(done), W'(1));

      // 2: 53 bytes plus 4 bits is rejected
      do_reset();
      fill(8'h02);
      push_exp(1'b0, '0);
      send_frame(NB - 1, 4);
      drain();
      chk("t2_valid", W'(frame_valid), '0);
      chk("t2_orientation", orientation, '0);
      chk("t2_done", W'(done), '0);

      // 3: illegal colour code, then a legal all-3 frame
      fill(8'h00);
      fb[10] = 8'h07;
      push_exp(1'b0, '0);
      send_frame(NB, 0);
      drain();
      chk("t3_bad_valid", W'(frame_valid), '0);
      fill(8'h03);
      push_exp(1'b1, pack_frame());
      send_frame(NB, 0);
      drain();
      chk("t3_valid", W'(frame_valid), W'(1));
      chk("t3_orientation", orientation, {NB{8'h03}});
      ack_pulse();

      // 4: 55 bytes overflows
      fill(8'h02);
      push_exp(1'b0, '0);
      frame_begin();
      for (int i = 0; i < NB + 1; i++) send_byte(fb[i]);
      tick(2);
      chk("t4_byte_count", W'(byte_count), W'(55));
      frame_end();
      drain();
      chk("t4_valid", W'(frame_valid), '0);

      // 5: double buffer, ack on the commit cycle of frame B
      fill(8'h01);
      frame_a = pack_frame();
      push_exp(1'b1, frame_a);
      send_frame(NB, 0);
      drain();
      fill(8'h04);
      push_exp(1'b1, pack_frame());
      frame_begin();
      for (int i = 0; i < NB; i++) send_byte(fb[i]);
      chk("t5_hold_a_mid", orientation, frame_a);
      tick(4);
      load = 1'b0;
      tick(SYNC + 1);
      frame_ack = 1'b1;
      chk("t5_hold_a_check", orientation, frame_a);
      tick(1);
      frame_ack = 1'b0;
      chk("t5_valid", W'(frame_valid), W'(1));
      chk("t5_done", W'(done), '0);
      chk("t5_orientation_b", orientation, {NB{8'h04}});
      drain();
      ack_pulse();
      chk("t5_ack_done", W'(done), W'(1));

      // 6: async reset mid-transfer
      fill(8'h05);
      frame_begin();
      for (int i = 0; i < 20; i++) send_byte(fb[i]);
      rst = 1'b1;
      #2;
      chk("t6_rst_orientation", orientation, '0);
      chk("t6_rst_done", W'(done), '0);
      chk("t6_rst_byte_count", W'(byte_count), '0);
      tick(3);
      rst = 1'b0;
      for (int i = 20; i < NB; i++) send_byte(fb[i]);
      frame_end();
      tick(20);
      chk("t6_no_commit", W'(frame_valid), '0);
      chk("t6_no_count", W'(byte_count), '0);
      for (int i = 0; i < 64; i++) fb[i] = 8'(5 - (i % 6));
      push_exp(1'b1, pack_frame());
      send_frame(NB, 0);
      drain();
      chk("t6_valid", W'(frame_valid), W'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
